// File: rtl/sc_fifo_if.sv
// Request/flag bundle shared by the FIFO and the stack buffer so clients can swap between them.
interface sc_fifo_if #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4
);
   logic              wrreq_i;
   logic [DWIDTH-1:0] data_i;
   logic              rdreq_i;
   logic [DWIDTH-1:0] q_o;
   logic              empty_o;
   logic              full_o;
   logic              almost_empty_o;
   logic              almost_full_o;
   logic [AWIDTH:0]   usedw_o;

   modport master (
      output wrreq_i, data_i, rdreq_i,
      input  q_o, empty_o, full_o, almost_empty_o, almost_full_o, usedw_o
   );

   modport slave (
      input  wrreq_i, data_i, rdreq_i,
      output q_o, empty_o, full_o, almost_empty_o, almost_full_o, usedw_o
   );
endinterface

// File: rtl/sc_fifo.sv
// Single-clock FIFO with sync RAM storage, registered read data and registered
// occupancy flags (including almost-full/almost-empty thresholds).
module sc_fifo #(
   parameter int DWIDTH       = 8,
   parameter int AWIDTH       = 4,
   parameter int ALMOST_FULL  = 12,
   parameter int ALMOST_EMPTY = 4
) (
   input  logic       clk_i,
   input  logic       srst_i,
   sc_fifo_if.slave   bus
);
   localparam int              DEPTH      = 2 ** AWIDTH;
   localparam logic [AWIDTH:0] FULL_COUNT = (AWIDTH + 1)'(DEPTH);
   localparam logic [AWIDTH:0] AF_LEVEL   = (AWIDTH + 1)'(ALMOST_FULL);
   localparam logic [AWIDTH:0] AE_LEVEL   = (AWIDTH + 1)'(ALMOST_EMPTY);
   localparam logic [AWIDTH:0] ONE        = (AWIDTH + 1)'(1);

   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic [AWIDTH-1:0] r_wrPtr;
   logic [AWIDTH-1:0] r_rdPtr;
   logic [AWIDTH:0]   r_usedw;
   logic [DWIDTH-1:0] r_q;
   logic              r_empty;
   logic              r_full;
   logic              r_almostEmpty;
   logic              r_almostFull;

   logic              w_wrAcc;
   logic              w_rdAcc;
   logic [AWIDTH:0]   w_usedwNext;

   // Acceptance uses the registered flags; flags are derived from the next count
   // so they always agree with usedw_o in the same cycle.
   always_comb begin
      w_wrAcc     = bus.wrreq_i & ~r_full;
      w_rdAcc     = bus.rdreq_i & ~r_empty;
      w_usedwNext = r_usedw;
      if (w_wrAcc && !w_rdAcc) begin
         w_usedwNext = r_usedw + ONE;
      end else if (w_rdAcc && !w_wrAcc) begin
         w_usedwNext = r_usedw - ONE;
      end
   end

   // Storage array has no reset so it maps onto block RAM; reset still blocks the write.
   always_ff @(posedge clk_i) begin
      if (w_wrAcc && !srst_i) begin
         r_mem[r_wrPtr] <= bus.data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_wrPtr       <= '0;
         r_rdPtr       <= '0;
         r_usedw       <= '0;
         r_q           <= '0;
         r_empty       <= 1'b1;
         r_full        <= 1'b0;
         r_almostEmpty <= 1'b1;
         r_almostFull  <= 1'b0;
      end else begin
         if (w_wrAcc) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         // With 1..DEPTH-1 words stored the pointers differ, so a simultaneous
         // write can never alias the word being read.
         if (w_rdAcc) begin
            r_q     <= r_mem[r_rdPtr];
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         r_usedw       <= w_usedwNext;
         r_empty       <= (w_usedwNext == '0);
         r_full        <= (w_usedwNext == FULL_COUNT);
         r_almostEmpty <= (w_usedwNext < AE_LEVEL);
         r_almostFull  <= (w_usedwNext >= AF_LEVEL);
      end
   end

   assign bus.q_o            = r_q;
   assign bus.usedw_o        = r_usedw;
   assign bus.empty_o        = r_empty;
   assign bus.full_o         = r_full;
   assign bus.almost_empty_o = r_almostEmpty;
   assign bus.almost_full_o  = r_almostFull;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!srst_i && bus.wrreq_i && r_full) begin
         $warning("sc_fifo: write request while full, dropped");
      end
      if (!srst_i && bus.rdreq_i && r_empty) begin
         $warning("sc_fifo: read request while empty, dropped");
      end
   end
`endif
endmodule

// File: tb/tb_sc_fifo.sv
// Self-checking bench for sc_fifo: fixed vector table, directed corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_sc_fifo;
   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 4;

   logic clk;
   logic srst;

   sc_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

   sc_fifo #(
      .DWIDTH(DW), .AWIDTH(AW), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
   ) dut (
      .clk_i (clk),
      .srst_i(srst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      bit          rd;
      logic [7:0]  data;
      bit          rst;
      int          expUsedw;
      logic [7:0]  expQ;
      bit          expEmpty;
      bit          expFull;
      bit          expAE;
      bit          expAF;
   } vec_t;

   vec_t       vecs [10];
   logic [7:0] modelQueue [$];
   logic [7:0] modelQ;
   int         passCount;
   int         totalCount;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCount++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         passCount++;
      end
   endtask

   // Drive one cycle of requests, advance the reference model, and wait past the edge.
   task automatic applyStimulus(input bit wr, input bit rd, input logic [7:0] data, input bit rst);
      bit wrA;
      bit rdA;
      bus.wrreq_i = wr;
      bus.rdreq_i = rd;
      bus.data_i  = data;
      srst        = rst;
      if (rst) begin
         modelQueue.delete();
         modelQ = 8'h00;
      end else begin
         wrA = wr && (modelQueue.size() < DEPTH);
         rdA = rd && (modelQueue.size() > 0);
         if (rdA) modelQ = modelQueue.pop_front();
         if (wrA) modelQueue.push_back(data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      int n;
      n = modelQueue.size();
      check({tag, ".q"},     32'(bus.q_o),            32'(modelQ));
      check({tag, ".usedw"}, 32'(bus.usedw_o),        32'(n));
      check({tag, ".empty"}, 32'(bus.empty_o),        32'(n == 0));
      check({tag, ".full"},  32'(bus.full_o),         32'(n == DEPTH));
      check({tag, ".aEmpty"},32'(bus.almost_empty_o), 32'(n < AE));
      check({tag, ".aFull"}, 32'(bus.almost_full_o),  32'(n >= AF));
   endtask

   task automatic drain();
      while (modelQueue.size() > 0) begin
         applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
         checkOutput("drain");
      end
   endtask

   initial begin
      passCount  = 0;
      totalCount = 0;
      modelQ     = 8'h00;
      bus.wrreq_i = 1'b0;
      bus.rdreq_i = 1'b0;
      bus.data_i  = 8'h00;
      srst        = 1'b0;

      //          wr  rd  data   rst usedw  q      emp full aE  aF
      vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 8'h11, 1'b0, 1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 8'h22, 1'b0, 2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 8'h33, 1'b0, 1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b0, 0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 8'h44, 1'b0, 1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 8'h55, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].data, vecs[i].rst);
         check($sformatf("vec%0d.q", i),      32'(bus.q_o),            32'(vecs[i].expQ));
         check($sformatf("vec%0d.usedw", i),  32'(bus.usedw_o),        32'(vecs[i].expUsedw));
         check($sformatf("vec%0d.empty", i),  32'(bus.empty_o),        32'(vecs[i].expEmpty));
         check($sformatf("vec%0d.full", i),   32'(bus.full_o),         32'(vecs[i].expFull));
         check($sformatf("vec%0d.aEmpty", i), 32'(bus.almost_empty_o), 32'(vecs[i].expAE));
         check($sformatf("vec%0d.aFull", i),  32'(bus.almost_full_o),  32'(vecs[i].expAF));
      end

      // Fill to full with 0x01..0x10.
      for (int i = 1; i <= DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
         checkOutput("fill");
         check("fill.aFullLevel", 32'(bus.almost_full_o), 32'(i >= AF));
      end
      check("fill.full", 32'(bus.full_o), 32'd1);
      check("fill.usedw", 32'(bus.usedw_o), 32'd16);

      // Drain in order, one cycle of read latency each.
      for (int i = 1; i <= DEPTH; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
         checkOutput("read");
         check("read.order", 32'(bus.q_o), 32'(i));
      end
      check("read.empty", 32'(bus.empty_o), 32'd1);

      // Overflow write is dropped and never reappears; read on empty holds q.
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(8'h21 + i), 1'b0);
      applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0);
      checkOutput("ovf");
      check("ovf.usedw", 32'(bus.usedw_o), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
         checkOutput("ovfDrain");
         check("ovfDrain.noAA", 32'(bus.q_o == 8'hAA), 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      check("underflow.hold", 32'(bus.q_o), 32'h30);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      check("underflow.usedw", 32'(bus.usedw_o), 32'd0);

      // Steady simultaneous read/write at 5 words across several pointer wraps.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
      for (int i = 5; i < 45; i++) begin
         applyStimulus(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
         checkOutput("rw");
         check("rw.usedw", 32'(bus.usedw_o), 32'd5);
         check("rw.seq", 32'(bus.q_o), 32'(8'(8'h80 + i - 5)));
      end
      drain();

      // Reset mid-burst with a write request pending.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 8'(8'h40 + i), (i == 6));
         checkOutput("burstRst");
      end
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      check("rst.usedw", 32'(bus.usedw_o), 32'd0);
      check("rst.empty", 32'(bus.empty_o), 32'd1);
      applyStimulus(1'b1, 1'b0, 8'h77, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      check("rst.newWord", 32'(bus.q_o), 32'h77);
      check("rst.emptyAgain", 32'(bus.empty_o), 32'd1);

      // Random traffic against the queue model.
      for (int i = 0; i < 10000; i++) begin
         applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                       8'($urandom), $urandom_range(0, 499) == 0);
         checkOutput("rand");
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end
endmodule
